// File: rtl/morse_tx_fsm.sv
// Morse transmitter: takes one character code per handshake, keys its dot/dash pattern
// on key_out and emits the matching 2-bit symbol stream for the receive/decode FSM.
module morse_tx_fsm #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic [1:0] sym_out,
  output logic       sym_strobe,
  output logic       busy,
  output logic       bad_char
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;
  localparam logic [1:0] CGAP  = 2'd3;

  // Timer reload values are "duration - 1" because the timer expires on reaching zero.
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(2 * UNIT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       pat;
  logic [2:0]       len;
  logic [2:0]       idx;
  logic [2:0]       idx_next;

  logic [2:0]       rom_len;
  logic [4:0]       rom_pat;
  logic             rom_valid;

  // Pattern is LSB-first (bit 0 = first element), 1 = dash; len 0 marks an unmapped code.
  always_comb begin
    rom_len = 3'd0;
    rom_pat = 5'b00000;
    case (char_in)
      8'h00: begin rom_len = 3'd2; rom_pat = 5'b00010; end // a .-
      8'h01: begin rom_len = 3'd4; rom_pat = 5'b00001; end // b -...
      8'h02: begin rom_len = 3'd4; rom_pat = 5'b00101; end // c -.-.
      8'h03: begin rom_len = 3'd3; rom_pat = 5'b00001; end // d -..
      8'h04: begin rom_len = 3'd1; rom_pat = 5'b00000; end // e .
      8'h05: begin rom_len = 3'd4; rom_pat = 5'b00100; end // f ..-.
      8'h06: begin rom_len = 3'd3; rom_pat = 5'b00011; end // g --.
      8'h07: begin rom_len = 3'd4; rom_pat = 5'b00000; end // h ....
      8'h08: begin rom_len = 3'd2; rom_pat = 5'b00000; end // i ..
      8'h09: begin rom_len = 3'd4; rom_pat = 5'b01110; end // j .---
      8'h0a: begin rom_len = 3'd3; rom_pat = 5'b00101; end // k -.-
      8'h0b: begin rom_len = 3'd4; rom_pat = 5'b00010; end // l .-..
      8'h0c: begin rom_len = 3'd2; rom_pat = 5'b00011; end // m --
      8'h0d: begin rom_len = 3'd2; rom_pat = 5'b00001; end // n -.
      8'h0e: begin rom_len = 3'd3; rom_pat = 5'b00111; end // o ---
      8'h0f: begin rom_len = 3'd4; rom_pat = 5'b00110; end // p .--.
      8'h10: begin rom_len = 3'd4; rom_pat = 5'b01011; end // q --.-
      8'h11: begin rom_len = 3'd3; rom_pat = 5'b00010; end // r .-.
      8'h12: begin rom_len = 3'd3; rom_pat = 5'b00000; end // s ...
      8'h13: begin rom_len = 3'd1; rom_pat = 5'b00001; end // t -
      8'h14: begin rom_len = 3'd3; rom_pat = 5'b00100; end // u ..-
      8'h15: begin rom_len = 3'd4; rom_pat = 5'b01000; end // v ...-
      8'h16: begin rom_len = 3'd3; rom_pat = 5'b00110; end // w .--
      8'h17: begin rom_len = 3'd4; rom_pat = 5'b01001; end // x -..-
      8'h18: begin rom_len = 3'd4; rom_pat = 5'b01101; end // y -.--
      8'h19: begin rom_len = 3'd4; rom_pat = 5'b00011; end // z --..
      8'h20: begin rom_len = 3'd5; rom_pat = 5'b11111; end // 0 -----
      8'h21: begin rom_len = 3'd5; rom_pat = 5'b11110; end // 1 .----
      8'h22: begin rom_len = 3'd5; rom_pat = 5'b11100; end // 2 ..---
      8'h23: begin rom_len = 3'd5; rom_pat = 5'b11000; end // 3 ...--
      8'h24: begin rom_len = 3'd5; rom_pat = 5'b10000; end // 4 ....-
      8'h25: begin rom_len = 3'd5; rom_pat = 5'b00000; end // 5 .....
      8'h26: begin rom_len = 3'd5; rom_pat = 5'b00001; end // 6 -....
      8'h27: begin rom_len = 3'd5; rom_pat = 5'b00011; end // 7 --...
      8'h28: begin rom_len = 3'd5; rom_pat = 5'b00111; end // 8 ---..
      8'h29: begin rom_len = 3'd5; rom_pat = 5'b01111; end // 9 ----.
      default: begin rom_len = 3'd0; rom_pat = 5'b00000; end
    endcase
  end

  assign rom_valid = (rom_len != 3'd0);
  assign idx_next  = idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pat        <= 5'b00000;
      len        <= 3'd0;
      idx        <= 3'd0;
      key_out    <= 1'b0;
      sym_out    <= 2'b00;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      bad_char   <= 1'b0;
      char_ready <= 1'b1;
    end else begin
      sym_out    <= 2'b00;
      sym_strobe <= 1'b0;
      bad_char   <= 1'b0;
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (rom_valid) begin
              pat        <= rom_pat;
              len        <= rom_len;
              idx        <= 3'd0;
              state      <= MARK;
              key_out    <= 1'b1;
              busy       <= 1'b1;
              char_ready <= 1'b0;
              cnt        <= rom_pat[0] ? DASH_LOAD : DOT_LOAD;
            end else begin
              bad_char <= 1'b1;
            end
          end
        end
        MARK: begin
          if (cnt == '0) begin
            state      <= SPACE;
            key_out    <= 1'b0;
            cnt        <= DOT_LOAD;
            sym_strobe <= 1'b1;
            sym_out    <= pat[idx] ? 2'b10 : 2'b01;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SPACE: begin
          if (cnt == '0) begin
            if (idx == len - 3'd1) begin
              state <= CGAP;
              cnt   <= GAP_LOAD;
            end else begin
              idx     <= idx_next;
              state   <= MARK;
              key_out <= 1'b1;
              cnt     <= pat[idx_next] ? DASH_LOAD : DOT_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // CGAP: the end-of-char strobe is raised as the timer enters its final cycle.
          if (cnt == '0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            char_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              sym_strobe <= 1'b1;
              sym_out    <= 2'b11;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_fsm.sv
// Bench for morse_tx_fsm: table of codes checked cycle-by-cycle against a waveform built
// from ITU dot/dash strings, plus back-to-back, invalid-code and mid-character reset cases.
module tb_morse_tx_fsm;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic [1:0] sym_out;
  logic       sym_strobe;
  logic       busy;
  logic       bad_char;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] code;
    int         tab;   // index into the Morse string table, -1 = no Morse entry
  } vec_t;

  vec_t vecs[40];

  morse_tx_fsm #(.UNIT_CYCLES(U), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .key_out(key_out), .sym_out(sym_out),
    .sym_strobe(sym_strobe), .busy(busy), .bad_char(bad_char)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string morse_of(input int i);
    case (i)
      0: return ".-";    1: return "-...";  2: return "-.-.";  3: return "-..";
      4: return ".";     5: return "..-.";  6: return "--.";   7: return "....";
      8: return "..";    9: return ".---"; 10: return "-.-";  11: return ".-..";
      12: return "--";  13: return "-.";   14: return "---";  15: return ".--.";
      16: return "--.-"; 17: return ".-."; 18: return "...";  19: return "-";
      20: return "..-"; 21: return "...-"; 22: return ".--";  23: return "-..-";
      24: return "-.--"; 25: return "--.."; 26: return "-----"; 27: return ".----";
      28: return "..---"; 29: return "...--"; 30: return "....-"; 31: return ".....";
      32: return "-...."; 33: return "--..."; 34: return "---.."; 35: return "----.";
      default: return "";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tally(input string name, input int bad, input int cyc,
                       input int act, input int exp);
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d bad cycles, first at N+%0d got %0h expected %0h",
               name, bad, cyc, act, exp);
    end
  endtask

  // Waits (bounded) for char_ready at a falling edge, then presents the code for one edge.
  // Returns positioned at the falling edge of cycle N+1 after the accept edge N.
  task automatic send(input logic [7:0] code, input bit hold);
    int w = 0;
    while (!char_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_wait: char_ready never rose, got 0 expected 1");
    end
    char_in    = code;
    char_valid = 1'b1;
    @(negedge clk);
    if (!hold) char_valid = 1'b0;
  endtask

  // Called at cycle N+1; checks the whole character, ends at cycle N+T+1 (IDLE expected).
  task automatic run_char(input string m, input string tag);
    int exp_key[$];
    int exp_sym[$];
    int kb = 0, kc = 0, ka = 0, ke = 0;
    int sb = 0, sc = 0, sa = 0, se = 0;
    int hb = 0, hc = 0, ha = 0;
    for (int i = 0; i < m.len(); i++) begin
      bit dash;
      dash = (m[i] == 8'h2d);
      for (int k = 0; k < (dash ? 3 * U : U); k++) begin
        exp_key.push_back(1); exp_sym.push_back(0);
      end
      exp_key.push_back(0); exp_sym.push_back(dash ? 2 : 1);
      for (int k = 1; k < U; k++) begin
        exp_key.push_back(0); exp_sym.push_back(0);
      end
    end
    for (int k = 1; k < 2 * U; k++) begin
      exp_key.push_back(0); exp_sym.push_back(0);
    end
    exp_key.push_back(0); exp_sym.push_back(3);

    for (int t = 0; t < exp_key.size(); t++) begin
      int sact, sexp;
      if (int'(key_out) != exp_key[t]) begin
        if (kb == 0) begin kc = t + 1; ka = int'(key_out); ke = exp_key[t]; end
        kb++;
      end
      sact = {29'd0, sym_strobe, sym_out};
      sexp = (exp_sym[t] != 0) ? (4 | exp_sym[t]) : 0;
      if (sact != sexp) begin
        if (sb == 0) begin sc = t + 1; sa = sact; se = sexp; end
        sb++;
      end
      if (char_ready !== 1'b0 || busy !== 1'b1) begin
        if (hb == 0) begin hc = t + 1; ha = {char_ready, busy}; end
        hb++;
      end
      @(negedge clk);
    end
    tally({tag, " key_out"}, kb, kc, ka, ke);
    tally({tag, " strobe/sym"}, sb, sc, sa, se);
    tally({tag, " ready/busy while sending"}, hb, hc, ha, 1);
    check({tag, " ready after char"}, {30'd0, char_ready, busy}, 32'h2);
  endtask

  task automatic bad_seq(input logic [7:0] code, input string tag);
    send(code, 1'b0);
    check({tag, " bad_char pulse"}, {31'd0, bad_char}, 32'd1);
    check({tag, " ready/key/strobe"}, {29'd0, char_ready, key_out, sym_strobe}, 32'h4);
    @(negedge clk);
    check({tag, " bad_char cleared"}, {29'd0, bad_char, key_out, sym_strobe}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 36; i++) begin
      vecs[i].code = (i < 26) ? 8'(i) : 8'(32 + i - 26);
      vecs[i].tab  = i;
    end
    vecs[36] = '{8'h1a, -1};
    vecs[37] = '{8'h1f, -1};
    vecs[38] = '{8'h2a, -1};
    vecs[39] = '{8'hff, -1};

    rst = 1'b1; char_in = 8'h00; char_valid = 1'b0;
    #2;
    check("reset state", {26'd0, key_out, sym_out, sym_strobe, busy, bad_char, char_ready},
          32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Every code in the table, one at a time.
    for (int v = 0; v < 40; v++) begin
      if (vecs[v].tab >= 0) begin
        send(vecs[v].code, 1'b0);
        run_char(morse_of(vecs[v].tab), $sformatf("code %02h", vecs[v].code));
      end else begin
        bad_seq(vecs[v].code, $sformatf("code %02h", vecs[v].code));
      end
    end

    // Back-to-back with valid held: t then e; char_in changes mid-character must be ignored.
    send(8'h13, 1'b1);
    char_in = 8'h04;
    run_char("-", "held t");
    @(negedge clk);
    char_valid = 1'b0;
    char_in    = 8'h1a;
    run_char(".", "held e");

    // Reset during the dash of 'a' (second mark occupies cycles N+9..N+20).
    send(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    check("a 2nd mark before reset", {31'd0, key_out}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("key_out async drop", {31'd0, key_out}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("no strobe in reset", {29'd0, sym_strobe, sym_out}, 32'd0);
    end
    rst = 1'b0;
    check("ready after reset", {30'd0, char_ready, busy}, 32'h2);
    send(8'h00, 1'b0);
    run_char(".-", "a after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
